varredura_matriz_leds: RTL and testbench
========================================

Name: varredura_matriz_leds

Overview:
- Downstream display stage for the battleship game controller.
- Consumes the five 7-bit column vectors (coluna1_saida..coluna5_saida) and time-multiplexes them onto the physical 5x7 LED matrix.
- Enables one column at a time and drives that column's active-low row pattern.
- Inserts a dark (blanking) gap between columns to prevent ghosting, and snapshots all columns once per frame so a frame never mixes old and new data.

Parameters:
CICLOS_POR_COLUNA, 50000, cycles each column is displayed (1 ms at 50 MHz); must be >= 1
CICLOS_BLANK, 8, dark cycles before each column; must be >= 1

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
habilitar  input  1  display enable (tied to game "ligado"); low = matrix dark
coluna1  input  7  column 1 pattern, bit0 = row 1, 0 = LED lit
coluna2  input  7  column 2 pattern, same encoding
coluna3  input  7  column 3 pattern
coluna4  input  7  column 4 pattern
coluna5  input  7  column 5 pattern
seletor_coluna  output  5  one-hot column enable, active-high, bit0 = column 1
linhas  output  7  row drive, active-low, bit0 = row 1
inicio_quadro  output  1  one-cycle pulse marking the frame-start snapshot

Behaviour:
- Clocking and reset: one clock, synchronous active-high reset.
- Reset state and values:
  - FSM = BLANK, indice = 0, contador = 0.
  - seletor_coluna = 5'b00000, linhas = 7'b1111111, inicio_quadro = 0.
  - Snapshot registers = 7'b1111111.
- Registered outputs: all outputs are registered and reflect the current FSM state. There is no combinational path from the coluna inputs to the outputs.
- FSM states: BLANK and EXIBE.
- BLANK:
  - seletor_coluna = 0, linhas = 7'h7F.
  - Lasts exactly CICLOS_BLANK cycles (contador 0..CICLOS_BLANK-1).
  - On the last count, go to EXIBE and clear contador.
- EXIBE:
  - seletor_coluna = one-hot(indice), linhas = snapshot[indice].
  - Lasts exactly CICLOS_POR_COLUNA cycles.
  - On the last count, go to BLANK, clear contador, and set indice = (indice == 4) ? 0 : indice + 1.
- Frame length: 5*(CICLOS_BLANK + CICLOS_POR_COLUNA) cycles.
- Snapshot timing:
  - All five coluna inputs are captured on the clock edge that ends the cycle with FSM = BLANK, indice = 0, contador = 0.
  - inicio_quadro is high during exactly that cycle.
  - Input changes at any other time do not reach the outputs before the next frame start.
- Invariants:
  - seletor_coluna is always 0 or one-hot.
  - seletor_coluna is never nonzero while in BLANK.
  - No glitch-free transition between columns is required, because the BLANK gap separates them.
- habilitar low:
  - On the next edge, go to the reset state (FSM, indice, contador and outputs). Snapshot registers are held.
  - The block remains there while habilitar is low; inicio_quadro stays 0.
- habilitar rising: the first high cycle is BLANK/indice 0/contador 0. It pulses inicio_quadro and captures a fresh snapshot.
- Priority: reset over habilitar.
- Reset or habilitar deasserting mid-EXIBE darkens the matrix on the next cycle; no partial column completion.
- Counter width: sized for max(CICLOS_POR_COLUNA, CICLOS_BLANK) - 1. Wrap is by explicit compare only, never by natural overflow.

Test Plan:
1. Reset held 3 cycles, habilitar=1 → seletor_coluna=00000, linhas=7F, inicio_quadro=0 throughout; after release, inicio_quadro=1 in cycle 0 only.
2. CICLOS_BLANK=2, CICLOS_POR_COLUNA=4; coluna1=7'b1111110, coluna3=7'b0111111, others 7F → in cycles 0-1 the matrix is dark; cycles 2-5 show seletor=00001/linhas=7E; cycles 6-7 dark; cycles 8-11 show 00010/7F; cycles 14-17 show 00100/3F; cycles 26-29 show 10000/7F; cycle 30 brings inicio_quadro=1 and BLANK.
3. Tearing: same params, change coluna3 to 7'b1110111 at cycle 10 → frame 1 still shows 3F in cycles 14-17; frame 2 (cycles 44-47) shows 77.
4. habilitar low at cycle 3 (mid-EXIBE col 1) → seletor=0/linhas=7F from cycle 4 onward; habilitar high again → inicio_quadro pulse on the first high cycle and column 1 shown two cycles later with the new snapshot.
5. reset and habilitar=0 asserted together mid-EXIBE col 4 → reset state next cycle; after both are released, the sequence restarts at column 1 exactly as in scenario 2.
6. Random coluna inputs over 1000 frames → every cycle seletor_coluna is 0 or one-hot, BLANK cycles are dark, and the displayed rows equal the value sampled at that frame's inicio_quadro.

Source files
------------

// File: rtl/varredura_matriz_leds.sv
// Purpose : column-scan driver for the 5x7 LED matrix; per-frame snapshot of the five columns,
//           with a dark gap before each column.
// Latency : column data is captured on the frame-start edge and appears CICLOS_BLANK cycles later.
//           habilitar/reset darken the matrix on the next cycle.
// Backpressure: none. The block free-runs while habilitar is high.
// Ports   : clock, reset (sync, active-high), habilitar (low = dark/idle), coluna1..5 (row patterns,
//           active-low, bit0 = row 1) -> seletor_coluna (one-hot, bit0 = column 1),
//           linhas (active-low rows), inicio_quadro (frame-start snapshot pulse).
module varredura_matriz_leds #(
    parameter int CICLOS_POR_COLUNA = 50000,
    parameter int CICLOS_BLANK      = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilitar,
    input  logic [6:0] coluna1,
    input  logic [6:0] coluna2,
    input  logic [6:0] coluna3,
    input  logic [6:0] coluna4,
    input  logic [6:0] coluna5,
    output logic [4:0] seletor_coluna,
    output logic [6:0] linhas,
    output logic       inicio_quadro
);

    localparam int CNT_MAX = ((CICLOS_POR_COLUNA > CICLOS_BLANK) ? CICLOS_POR_COLUNA : CICLOS_BLANK) - 1;
    localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] ULT_BLANK = CW'(CICLOS_BLANK - 1);
    localparam logic [CW-1:0] ULT_EXIBE = CW'(CICLOS_POR_COLUNA - 1);

    typedef enum logic {
        BLANK = 1'b0,
        EXIBE = 1'b1
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [2:0]       indice_q, indice_d;
    logic [CW-1:0]    contador_q, contador_d;
    logic [4:0][6:0]  snap_q, snap_d;
    logic [4:0]       seletor_q, seletor_d;
    logic [6:0]       linhas_q, linhas_d;
    logic             captura;

    // The idle/reset state is BLANK/0/0, so the first enabled cycle is frame cycle 0 and
    // performs the snapshot without any extra start-up cycle.
    assign captura = habilitar && (estado_q == BLANK) && (indice_q == 3'd0) && (contador_q == '0);

    always_comb begin
        estado_d   = estado_q;
        indice_d   = indice_q;
        contador_d = contador_q;
        snap_d     = snap_q;
        seletor_d  = 5'b00000;
        linhas_d   = 7'h7F;

        if (captura) begin
            snap_d = {coluna5, coluna4, coluna3, coluna2, coluna1};
        end

        if (!habilitar) begin
            estado_d   = BLANK;
            indice_d   = 3'd0;
            contador_d = '0;
        end else begin
            case (estado_q)
                BLANK: begin
                    if (contador_q == ULT_BLANK) begin
                        estado_d   = EXIBE;
                        contador_d = '0;
                    end else begin
                        contador_d = contador_q + CW'(1);
                    end
                end
                EXIBE: begin
                    if (contador_q == ULT_EXIBE) begin
                        estado_d   = BLANK;
                        contador_d = '0;
                        indice_d   = (indice_q == 3'd4) ? 3'd0 : indice_q + 3'd1;
                    end else begin
                        contador_d = contador_q + CW'(1);
                    end
                end
                default: begin
                    estado_d   = BLANK;
                    indice_d   = 3'd0;
                    contador_d = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so the registered value matches the
        // state the machine is in. snap_d is used so that CICLOS_BLANK = 1 still shows
        // the freshly captured column 1.
        if (estado_d == EXIBE) begin
            seletor_d = 5'(5'b00001 << indice_d);
            linhas_d  = snap_d[indice_d];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= BLANK;
            indice_q   <= 3'd0;
            contador_q <= '0;
            snap_q     <= {5{7'h7F}};
            seletor_q  <= 5'b00000;
            linhas_q   <= 7'h7F;
        end else begin
            estado_q   <= estado_d;
            indice_q   <= indice_d;
            contador_q <= contador_d;
            snap_q     <= snap_d;
            seletor_q  <= seletor_d;
            linhas_q   <= linhas_d;
        end
    end

    assign seletor_coluna = seletor_q;
    assign linhas         = linhas_q;
    // Decoded from registered state; gated so it stays low while reset or disabled.
    assign inicio_quadro  = captura && !reset;

endmodule

// File: tb/tb_varredura_matriz_leds.sv
module tb_varredura_matriz_leds;

    localparam int NB = 2;
    localparam int NC = 4;
    localparam int FR = 5 * (NB + NC);

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       habilitar = 1'b1;
    logic [6:0] c1 = 7'h7F, c2 = 7'h7F, c3 = 7'h7F, c4 = 7'h7F, c5 = 7'h7F;
    logic [4:0] seletor_coluna;
    logic [6:0] linhas;
    logic       inicio_quadro;

    varredura_matriz_leds #(
        .CICLOS_POR_COLUNA(NC),
        .CICLOS_BLANK     (NB)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .habilitar     (habilitar),
        .coluna1       (c1),
        .coluna2       (c2),
        .coluna3       (c3),
        .coluna4       (c4),
        .coluna5       (c5),
        .seletor_coluna(seletor_coluna),
        .linhas        (linhas),
        .inicio_quadro (inicio_quadro)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [4:0] sel;
        logic [6:0] lin;
        logic       ini;
    } exp_t;

    exp_t fila[$];
    int   total = 0;
    int   bad   = 0;
    logic rnd_on = 1'b0;
    int   pos = 0;
    logic [4:0][6:0] rsnap = {5{7'h7F}};
    exp_t em;

    // Frame cycle k: 6-cycle slots, 2 dark then 4 lit, column = slot number.
    function automatic exp_t esperado(int t, int k, logic [4:0][6:0] p);
        exp_t e;
        int col;
        int ph;
        col   = k / (NB + NC);
        ph    = k % (NB + NC);
        e.cyc = t;
        e.ini = (k == 0);
        e.sel = 5'b00000;
        e.lin = 7'h7F;
        if (ph >= NB) begin
            e.sel = 5'(1 << col);
            e.lin = p[col];
        end
        return e;
    endfunction

    task automatic push_frame(input int t0, input logic [4:0][6:0] p, input int nk);
        for (int k = 0; k < nk; k++) fila.push_back(esperado(t0 + k, k, p));
    endtask

    task automatic push_dark(input int t);
        exp_t e;
        e.cyc = t;
        e.sel = 5'b00000;
        e.lin = 7'h7F;
        e.ini = 1'b0;
        fila.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Monitor: compares every cycle that has a queued expectation, plus the random-phase checks.
    always @(negedge clock) begin
        while (fila.size() > 0 && fila[0].cyc < cyc) begin
            em = fila.pop_front();
            total++;
            bad++;
            $display("FAIL stale_expectation cyc=%0d now=%0d", em.cyc, cyc);
        end
        while (fila.size() > 0 && fila[0].cyc == cyc) begin
            em = fila.pop_front();
            total++;
            if ({seletor_coluna, linhas, inicio_quadro} !== {em.sel, em.lin, em.ini}) begin
                bad++;
                $display("FAIL scoreboard cyc=%0d got sel=%b lin=%h ini=%b want sel=%b lin=%h ini=%b",
                         cyc, seletor_coluna, linhas, inicio_quadro, em.sel, em.lin, em.ini);
            end
        end
        if (rnd_on) begin
            if (inicio_quadro === 1'b1) begin
                pos   = 0;
                rsnap = {c5, c4, c3, c2, c1};
            end
            em = esperado(cyc, pos % FR, rsnap);
            total++;
            if ({seletor_coluna, linhas, inicio_quadro} !== {em.sel, em.lin, em.ini}) begin
                bad++;
                $display("FAIL random_frame cyc=%0d pos=%0d got sel=%b lin=%h ini=%b want sel=%b lin=%h ini=%b",
                         cyc, pos % FR, seletor_coluna, linhas, inicio_quadro, em.sel, em.lin, em.ini);
            end
            total++;
            if (!$onehot0(seletor_coluna)) begin
                bad++;
                $display("FAIL onehot0 cyc=%0d got sel=%b want zero or one-hot", cyc, seletor_coluna);
            end
            pos++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        int t0;
        int h;
        logic [4:0][6:0] p1;
        logic [4:0][6:0] p2;
        logic [4:0][6:0] p3;

        p1 = {7'h7F, 7'h7F, 7'h3F, 7'h7F, 7'h7E};
        p2 = {7'h7F, 7'h7F, 7'h77, 7'h7F, 7'h7E};
        p3 = {7'h3C, 7'h5A, 7'h00, 7'h15, 7'h2A};

        // Reset held for three cycles: dark, no pulse.
        @(posedge clock);
        #1;
        t = cyc;
        for (int i = 0; i < 3; i++) push_dark(t + i);
        goto(t + 2);
        c1 = p1[0]; c2 = p1[1]; c3 = p1[2]; c4 = p1[3]; c5 = p1[4];
        goto(t + 3);
        reset = 1'b0;
        t0 = cyc;

        // Frame 1 with p1, frame 2 with the mid-frame-1 change, start of frame 3.
        push_frame(t0, p1, FR);
        push_frame(t0 + FR, p2, FR);
        push_frame(t0 + 2 * FR, p2, 4);
        for (int i = 4; i < 8; i++) push_dark(t0 + 2 * FR + i);

        goto(t0 + 10);
        c3 = 7'h77;

        // habilitar drops mid column 1, new data loaded while dark.
        goto(t0 + 2 * FR + 3);
        habilitar = 1'b0;
        c1 = p3[0]; c2 = p3[1]; c3 = p3[2]; c4 = p3[3]; c5 = p3[4];
        goto(t0 + 2 * FR + 8);
        habilitar = 1'b1;
        h = cyc;
        push_frame(h, p3, 22);
        push_dark(h + 22);
        push_dark(h + 23);
        push_frame(h + 24, p3, FR);

        // reset and habilitar low together mid column 4.
        goto(h + 21);
        reset = 1'b1;
        habilitar = 1'b0;
        goto(h + 24);
        reset = 1'b0;
        habilitar = 1'b1;

        // Random column data over 1000 frames.
        goto(h + 24 + FR);
        rnd_on = 1'b1;
        for (int f = 0; f < 1000 * FR; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                c1 = 7'($urandom); c2 = 7'($urandom); c3 = 7'($urandom);
                c4 = 7'($urandom); c5 = 7'($urandom);
            end
            @(posedge clock);
            #1;
        end
        rnd_on = 1'b0;
        @(posedge clock);
        #1;

        total++;
        if (fila.size() != 0) begin
            bad++;
            $display("FAIL leftover_expectations got %0d want 0", fila.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
